// File: rtl/sipo_deserializer.sv
// ---------------------------------------------------------------------------
// sipo_deserializer
//   Serial-in / parallel-out word assembler with a valid/ack handshake and a
//   sticky overrun flag. The shift register and frame counter advance only on
//   enabled clock edges, so the serial source may insert gaps of any length
//   between bits. All outputs come straight from registers.
//
// Parameters
//   WIDTH      word length in bits (2..32)
//   MSB_FIRST  1: first received bit ends up in q_o[WIDTH-1]
//              0: first received bit ends up in q_o[0]
//
// Ports
//   clk_i      rising-edge clock
//   clr_i      synchronous active-high reset, overrides every other input
//   d_i        serial data bit, sampled when en_i=1
//   en_i       shift enable, one bit consumed per enabled edge
//   flush_i    drop the partial frame (bits, count); q/valid/overrun kept
//   ack_i      consumer acknowledge, clears valid_o
//   q_o        last completed word, held until the next word completes
//   valid_o    completed word pending
//   busy_o     partial frame in progress (cnt_o != 0)
//   cnt_o      bits collected in the current frame, 0..WIDTH-1
//   overrun_o  sticky: a word completed while the previous one was unacked
// ---------------------------------------------------------------------------
module sipo_deserializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  localparam int CW       = $clog2(WIDTH)
) (
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic             d_i,
  input  logic             en_i,
  input  logic             flush_i,
  input  logic             ack_i,
  output logic [WIDTH-1:0] q_o,
  output logic             valid_o,
  output logic             busy_o,
  output logic [CW-1:0]    cnt_o,
  output logic             overrun_o
);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  state_t             state_q;
  logic [WIDTH-1:0]   sr_q;
  logic [WIDTH-1:0]   sr_d;
  logic [CW-1:0]      cnt_q;
  logic [WIDTH-1:0]   q_q;
  logic               valid_q;
  logic               busy_q;
  logic               overrun_q;

  logic               shift_en;
  logic               done;

  // Shifted value including the current bit; this is also the completed word
  // on the last bit of a frame, so q can be loaded from it directly.
  generate
    if (MSB_FIRST) begin : g_msb
      assign sr_d = {sr_q[WIDTH-2:0], d_i};
    end else begin : g_lsb
      assign sr_d = {d_i, sr_q[WIDTH-1:1]};
    end
  endgenerate

  // flush outranks en, so a bit presented alongside flush is dropped.
  assign shift_en = en_i & ~flush_i;
  assign done     = shift_en & (cnt_q == LAST_CNT);

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      state_q   <= IDLE;
      sr_q      <= '0;
      cnt_q     <= '0;
      q_q       <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      // Frame state machine. IDLE and SHIFT only differ by whether any bit
      // of the current frame has been collected; busy mirrors that.
      case (state_q)
        IDLE: begin
          if (shift_en) begin
            sr_q <= sr_d;
            if (done) begin
              // only reachable when a frame is one bit long
              cnt_q  <= '0;
              q_q    <= sr_d;
              busy_q <= 1'b0;
            end else begin
              cnt_q   <= cnt_q + 1'b1;
              busy_q  <= 1'b1;
              state_q <= SHIFT;
            end
          end else if (flush_i) begin
            sr_q <= '0;
          end
        end
        SHIFT: begin
          if (flush_i) begin
            sr_q    <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (shift_en) begin
            sr_q <= sr_d;
            if (done) begin
              cnt_q   <= '0;
              q_q     <= sr_d;
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase

      // Handshake runs beside the frame logic. A completing word always
      // wins over ack, so a word landing in the ack cycle stays pending.
      if (done)
        valid_q <= 1'b1;
      else if (ack_i)
        valid_q <= 1'b0;

      // Previous word overwritten before the consumer took it.
      if (done && valid_q && !ack_i)
        overrun_q <= 1'b1;
    end
  end

  assign q_o       = q_q;
  assign valid_o   = valid_q;
  assign busy_o    = busy_q;
  assign cnt_o     = cnt_q;
  assign overrun_o = overrun_q;

endmodule

// File: tb/tb_sipo_deserializer.sv
module tb_sipo_deserializer;

  logic       clk;
  logic       clr, d, en, flush, ack;
  logic [7:0] q_m, q_l;
  logic       valid_m, valid_l, busy_m, busy_l, ovr_m, ovr_l;
  logic [2:0] cnt_m, cnt_l;

  int checks = 0;
  int errors = 0;

  sipo_deserializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .clk_i(clk), .clr_i(clr), .d_i(d), .en_i(en), .flush_i(flush), .ack_i(ack),
    .q_o(q_m), .valid_o(valid_m), .busy_o(busy_m), .cnt_o(cnt_m), .overrun_o(ovr_m)
  );

  sipo_deserializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk_i(clk), .clr_i(clr), .d_i(d), .en_i(en), .flush_i(flush), .ack_i(ack),
    .q_o(q_l), .valid_o(valid_l), .busy_o(busy_l), .cnt_o(cnt_l), .overrun_o(ovr_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input logic a);
    d = b; en = 1'b1; ack = a;
    tick();
    en = 1'b0; ack = 1'b0; d = 1'b0;
  endtask

  // Bits go out w[7] first; ack_last raises ack on the final bit only.
  task automatic send_word(input logic [7:0] w, input logic ack_last);
    for (int i = 7; i >= 0; i--)
      send_bit(w[i], (i == 0) ? ack_last : 1'b0);
  endtask

  task automatic do_ack();
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  task automatic test_reset();
    clr = 1'b1;
    tick(); tick();
    clr = 1'b0;
    checks++; if (q_m !== 8'h00) begin errors++; $display("FAIL reset_q got %h exp %h", q_m, 8'h00); end
    checks++; if (valid_m !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", valid_m); end
    checks++; if (busy_m !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy_m); end
    checks++; if (cnt_m !== 3'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", cnt_m); end
    checks++; if (ovr_m !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b exp 0", ovr_m); end
  endtask

  task automatic test_basic();
    logic [7:0] bits;
    logic [2:0] exp_cnt;
    bits = 8'b1011_0010;
    for (int i = 7; i >= 0; i--) begin
      send_bit(bits[i], 1'b0);
      exp_cnt = 3'(8 - i);
      checks++; if (cnt_m !== exp_cnt) begin errors++; $display("FAIL basic_cnt bit%0d got %0d exp %0d", 7 - i, cnt_m, exp_cnt); end
      if (i != 0) begin
        checks++; if (busy_m !== 1'b1) begin errors++; $display("FAIL basic_busy bit%0d got %b exp 1", 7 - i, busy_m); end
      end
    end
    checks++; if (q_m !== 8'hB2) begin errors++; $display("FAIL basic_q_msb got %h exp %h", q_m, 8'hB2); end
    checks++; if (q_l !== 8'h4D) begin errors++; $display("FAIL basic_q_lsb got %h exp %h", q_l, 8'h4D); end
    checks++; if (valid_m !== 1'b1) begin errors++; $display("FAIL basic_valid got %b exp 1", valid_m); end
    checks++; if (busy_m !== 1'b0) begin errors++; $display("FAIL basic_busy_end got %b exp 0", busy_m); end
    checks++; if (ovr_m !== 1'b0) begin errors++; $display("FAIL basic_overrun got %b exp 0", ovr_m); end
    do_ack();
    checks++; if (valid_m !== 1'b0) begin errors++; $display("FAIL basic_ack got %b exp 0", valid_m); end
    checks++; if (q_m !== 8'hB2) begin errors++; $display("FAIL basic_q_hold got %h exp %h", q_m, 8'hB2); end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
    checks++; if (cnt_m !== 3'd4) begin errors++; $display("FAIL flush_pre_cnt got %0d exp 4", cnt_m); end
    flush = 1'b1; en = 1'b1; d = 1'b1;
    tick();
    flush = 1'b0; en = 1'b0; d = 1'b0;
    checks++; if (cnt_m !== 3'd0) begin errors++; $display("FAIL flush_cnt got %0d exp 0", cnt_m); end
    checks++; if (busy_m !== 1'b0) begin errors++; $display("FAIL flush_busy got %b exp 0", busy_m); end
    checks++; if (q_m !== 8'hB2) begin errors++; $display("FAIL flush_q_hold got %h exp %h", q_m, 8'hB2); end
    checks++; if (valid_m !== 1'b0) begin errors++; $display("FAIL flush_valid_hold got %b exp 0", valid_m); end
    send_word(8'h0F, 1'b0);
    checks++; if (q_m !== 8'h0F) begin errors++; $display("FAIL flush_q_msb got %h exp %h", q_m, 8'h0F); end
    checks++; if (q_l !== 8'hF0) begin errors++; $display("FAIL flush_q_lsb got %h exp %h", q_l, 8'hF0); end
    checks++; if (valid_m !== 1'b1) begin errors++; $display("FAIL flush_valid got %b exp 1", valid_m); end
    do_ack();
  endtask

  task automatic test_back_to_back_overrun();
    send_word(8'hA5, 1'b0);
    checks++; if (q_m !== 8'hA5) begin errors++; $display("FAIL b2b_q1 got %h exp %h", q_m, 8'hA5); end
    checks++; if (valid_m !== 1'b1) begin errors++; $display("FAIL b2b_valid1 got %b exp 1", valid_m); end
    checks++; if (ovr_m !== 1'b0) begin errors++; $display("FAIL b2b_ovr1 got %b exp 0", ovr_m); end
    send_word(8'h3C, 1'b0);
    checks++; if (q_m !== 8'h3C) begin errors++; $display("FAIL b2b_q2 got %h exp %h", q_m, 8'h3C); end
    checks++; if (valid_m !== 1'b1) begin errors++; $display("FAIL b2b_valid2 got %b exp 1", valid_m); end
    checks++; if (ovr_m !== 1'b1) begin errors++; $display("FAIL b2b_ovr2 got %b exp 1", ovr_m); end
    do_ack();
    tick();
    checks++; if (valid_m !== 1'b0) begin errors++; $display("FAIL b2b_ack got %b exp 0", valid_m); end
    checks++; if (ovr_m !== 1'b1) begin errors++; $display("FAIL b2b_ovr_sticky got %b exp 1", ovr_m); end
    clr = 1'b1; tick(); clr = 1'b0;
    checks++; if (ovr_m !== 1'b0) begin errors++; $display("FAIL b2b_ovr_clr got %b exp 0", ovr_m); end
  endtask

  task automatic test_ack_collision();
    send_word(8'h81, 1'b0);
    checks++; if (q_m !== 8'h81) begin errors++; $display("FAIL coll_q1 got %h exp %h", q_m, 8'h81); end
    send_word(8'h7E, 1'b1);
    checks++; if (valid_m !== 1'b1) begin errors++; $display("FAIL coll_valid got %b exp 1", valid_m); end
    checks++; if (q_m !== 8'h7E) begin errors++; $display("FAIL coll_q2 got %h exp %h", q_m, 8'h7E); end
    checks++; if (ovr_m !== 1'b0) begin errors++; $display("FAIL coll_ovr got %b exp 0", ovr_m); end
    do_ack();
    checks++; if (valid_m !== 1'b0) begin errors++; $display("FAIL coll_ack got %b exp 0", valid_m); end
    // ack with nothing pending has no effect
    do_ack();
    checks++; if (valid_m !== 1'b0 || q_m !== 8'h7E) begin errors++; $display("FAIL coll_idle_ack got valid %b q %h exp valid 0 q 7e", valid_m, q_m); end
  endtask

  task automatic test_gap_clr();
    send_word(8'h55, 1'b0);
    for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0);
    for (int i = 0; i < 10; i++) tick();
    checks++; if (cnt_m !== 3'd5) begin errors++; $display("FAIL gap_cnt got %0d exp 5", cnt_m); end
    checks++; if (busy_m !== 1'b1) begin errors++; $display("FAIL gap_busy got %b exp 1", busy_m); end
    clr = 1'b1; en = 1'b1; d = 1'b1;
    tick();
    clr = 1'b0; en = 1'b0; d = 1'b0;
    checks++; if (q_m !== 8'h00) begin errors++; $display("FAIL gap_clr_q got %h exp 00", q_m); end
    checks++; if (valid_m !== 1'b0) begin errors++; $display("FAIL gap_clr_valid got %b exp 0", valid_m); end
    checks++; if (cnt_m !== 3'd0) begin errors++; $display("FAIL gap_clr_cnt got %0d exp 0", cnt_m); end
    checks++; if (busy_m !== 1'b0) begin errors++; $display("FAIL gap_clr_busy got %b exp 0", busy_m); end
    send_word(8'hFF, 1'b0);
    checks++; if (q_m !== 8'hFF) begin errors++; $display("FAIL gap_q got %h exp ff", q_m); end
    checks++; if (valid_m !== 1'b1) begin errors++; $display("FAIL gap_valid got %b exp 1", valid_m); end
  endtask

  initial begin
    clr = 1'b1; d = 1'b0; en = 1'b0; flush = 1'b0; ack = 1'b0;
    #1;
    test_reset();
    test_basic();
    test_flush();
    test_back_to_back_overrun();
    test_ack_collision();
    test_gap_clr();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sipo_deserializer.md
Name: sipo_deserializer

Overview:
Serial-in, parallel-out deserializer built as the consumer stage for a chain of D flip-flops. It samples a serial bit stream on enabled clock edges and assembles WIDTH-bit words. Each completed word is presented on a parallel output with a valid/ack handshake. A sticky overrun flag reports words lost because the consumer did not acknowledge in time.

Parameters:
WIDTH, 8, word length in bits (legal range 2..32)
MSB_FIRST, 1, 1 = first received bit lands in q[WIDTH-1]; 0 = first received bit lands in q[0]

Ports:
clk  input  1  rising-edge clock
clr  input  1  synchronous active-high reset
d  input  1  serial data bit, sampled only when en=1
en  input  1  shift enable; each rising clk with en=1 consumes one bit
flush  input  1  abort partial frame: discard collected bits and return count to 0
ack  input  1  consumer acknowledge; clears valid
q  output  WIDTH  last completed word, held until the next word completes
valid  output  1  completed word pending, level signal
busy  output  1  partial frame in progress (cnt != 0)
cnt  output  CW  bits collected in the current frame, 0..WIDTH-1, where CW = $clog2(WIDTH)
overrun  output  1  sticky: a word completed while the previous word was still unacknowledged

Behaviour:
- All state updates on rising clk only. Nothing is combinational from inputs to outputs.
- Reset (clr=1): q=0, valid=0, busy=0, cnt=0, overrun=0, internal shift register=0. clr overrides every other input in that cycle.
- Priority per cycle: clr > flush > en. ack is evaluated independently of the frame logic.
- State machine:
  - IDLE: cnt=0, busy=0.
  - SHIFT: 0<cnt<WIDTH, busy=1.
  - IDLE -> SHIFT on en=1 without flush (when WIDTH>1).
  - SHIFT -> IDLE on word completion or flush.
- Shift, when en=1 and flush=0:
  - MSB_FIRST=1: sr <= {sr[WIDTH-2:0], d}.
  - MSB_FIRST=0: sr <= {d, sr[WIDTH-1:1]}.
  - cnt increments by 1.
- Completion: when en=1, flush=0 and cnt==WIDTH-1:
  - q <= shifted value, including the current d.
  - cnt <= 0.
  - valid <= 1.
  - The new word is visible the cycle after the WIDTH-th enabled edge (latency 1 clk from the last bit).
- Back-to-back words: en may stay high continuously. The next frame starts on the cycle immediately after completion with no gap bit.
- en=0 holds sr, cnt and busy. Gaps between bits are allowed and unbounded.
- flush=1: cnt <= 0, busy <= 0, sr <= 0. q, valid and overrun are unchanged. A bit presented with en in the same cycle is dropped.
- Handshake:
  - ack=1 while valid=1 clears valid next cycle.
  - ack while valid=0 is ignored.
  - Completion and ack in the same cycle: valid stays 1 (new word), q takes the new word, overrun is not set.
- Overrun: completion while valid=1 and ack=0 sets overrun=1. q is overwritten with the new word and valid stays 1. overrun clears only on clr.
- cnt wraps WIDTH-1 -> 0 only through completion. It never reaches WIDTH.
- clr mid-frame discards partial bits and any pending word.
- Gate-level D flip-flop cells may be used for sr storage, provided the synchronous clr semantics above hold.

Test Plan:
- WIDTH=8, MSB_FIRST=1, clr 2 cycles, then en=1 with d=1,0,1,1,0,0,1,0 on consecutive edges -> cnt 1..7 then 0; valid=1 and q=8'hB2 one cycle after the 8th bit; busy=0.
- Same bits with MSB_FIRST=0 -> q=8'h4D.
- Send 4 bits (1,1,1,1), assert flush with en=1, then send 8 bits 0x0F MSB-first -> q=8'h0F (the flushed bits do not appear); q and valid are unchanged during flush.
- 16 continuous enabled bits (0xA5 then 0x3C) with ack never asserted -> after the first word q=8'hA5, valid=1, overrun=0; after the second q=8'h3C, valid=1, overrun=1; overrun stays 1 until clr.
- Word 0x81 completes, then 0x7E completes in the same cycle ack=1 -> valid stays 1, q=8'h7E, overrun=0; ack next cycle -> valid=0.
- 5 bits received, en deasserted for 10 cycles, clr pulsed for 1 cycle -> q=0, valid=0, cnt=0, busy=0; a following 8-bit 0xFF frame yields q=8'hFF.
